// File: rtl/sevenseg_if.sv
// Segment-display bus: datapath nibbles and blanking in, active-low segment/anode pins out.
interface sevenseg_if #(
  parameter int unsigned N_DIGITS = 2
);
  logic [4*N_DIGITS-1:0] digits;
  logic [N_DIGITS-1:0]   blank;
  logic [6:0]            segs;
  logic [N_DIGITS-1:0]   anodes;
  logic                  scan_done;

  modport master (output digits, blank, input segs, anodes, scan_done);
  modport slave  (input digits, blank, output segs, anodes, scan_done);
endinterface

// File: rtl/sevenseg_scan.sv
// Time-multiplexed N-digit seven-segment driver with dead time and per-frame input snapshots.
// Define SEVENSEG_LZB_EN to enable leading-zero blanking.
module sevenseg_scan #(
  parameter int unsigned N_DIGITS       = 2,
  parameter int unsigned REFRESH_CYCLES = 48000,
  parameter int unsigned DEAD_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       reset,
  sevenseg_if.slave  bus
);

  localparam int unsigned CntW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned IdxW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax   = CntW'(REFRESH_CYCLES - 1);
  localparam logic [CntW-1:0] DeadLast = CntW'(DEAD_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxMax   = IdxW'(N_DIGITS - 1);

  typedef enum logic {StDead, StOn} phase_e;

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  phase_e                phase_q, phase_d;
  logic [4*N_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [N_DIGITS-1:0]   snap_blank_q, snap_blank_d;
  logic [6:0]            segs_q, segs_d;
  logic [N_DIGITS-1:0]   anodes_q, anodes_d;
  logic                  scan_done_q, scan_done_d;
  logic [N_DIGITS-1:0]   lz_blank;
  logic [N_DIGITS-1:0]   eff_blank;
  logic [3:0]            nibble;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'b1000000;
      4'h1: seg_decode = 7'b1111001;
      4'h2: seg_decode = 7'b0100100;
      4'h3: seg_decode = 7'b0110000;
      4'h4: seg_decode = 7'b0011001;
      4'h5: seg_decode = 7'b0010010;
      4'h6: seg_decode = 7'b0000010;
      4'h7: seg_decode = 7'b1111000;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0010000;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b0000011;
      4'hC: seg_decode = 7'b1000110;
      4'hD: seg_decode = 7'b0100001;
      4'hE: seg_decode = 7'b0000110;
      default: seg_decode = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      phase_q       <= StDead;
      snap_digits_q <= '0;
      snap_blank_q  <= '0;
      segs_q        <= 7'h7F;
      anodes_q      <= '1;
      scan_done_q   <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      phase_q       <= phase_d;
      snap_digits_q <= snap_digits_d;
      snap_blank_q  <= snap_blank_d;
      segs_q        <= segs_d;
      anodes_q      <= anodes_d;
      scan_done_q   <= scan_done_d;
    end
  end

  always_comb begin
    cnt_d         = cnt_q + 1'b1;
    idx_d         = idx_q;
    scan_done_d   = 1'b0;
    snap_digits_d = snap_digits_q;
    snap_blank_d  = snap_blank_q;
    phase_d       = phase_q;
    if (cnt_q == CntMax) begin
      cnt_d = '0;
      if (idx_q == IdxMax) begin
        idx_d       = '0;
        scan_done_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    // Frame start: capture inputs so the whole scan shows one consistent value.
    if (cnt_q == '0 && idx_q == '0) begin
      snap_digits_d = bus.digits;
      snap_blank_d  = bus.blank;
    end
    unique case (phase_q)
      StDead: if (cnt_q == DeadLast) phase_d = StOn;
      StOn:   if (cnt_q == CntMax)   phase_d = StDead;
      default: phase_d = StDead;
    endcase
  end

`ifdef SEVENSEG_LZB_EN
  always_comb begin
    logic zero_above;
    lz_blank   = '0;
    zero_above = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_above  = zero_above & (snap_digits_d[4*i +: 4] == 4'h0);
      lz_blank[i] = zero_above;
    end
  end
`else
  assign lz_blank = '0;
`endif

  assign eff_blank = snap_blank_d | lz_blank;
  assign nibble    = snap_digits_d[{idx_d, 2'b00} +: 4];

  always_comb begin
    segs_d   = 7'h7F;
    anodes_d = '1;
    if (phase_d == StOn) begin
      segs_d = seg_decode(nibble);
      if (!eff_blank[idx_d]) anodes_d[idx_d] = 1'b0;
    end
  end

  assign bus.segs      = segs_q;
  assign bus.anodes    = anodes_q;
  assign bus.scan_done = scan_done_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan: directed scenarios, decode table sweep, and a
// randomized run compared cycle by cycle against an edge-count reference model.
module tb_sevenseg_scan;
  localparam int unsigned N  = 2;
  localparam int unsigned R  = 8;
  localparam int unsigned D  = 2;
  localparam int unsigned NR = N * R;
`ifdef SEVENSEG_LZB_EN
  localparam bit Lzb = 1'b1;
`else
  localparam bit Lzb = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  sevenseg_if #(.N_DIGITS(N)) ss_if ();

  sevenseg_scan #(
    .N_DIGITS      (N),
    .REFRESH_CYCLES(R),
    .DEAD_CYCLES   (D)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ss_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] nib;
    logic [6:0] segs;
  } dec_vec_t;

  dec_vec_t    dec_tab[16];
  logic [6:0]  seg_ref[16];
  int unsigned k;
  logic [7:0]  m_dig;
  logic [1:0]  m_blk;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, k);
    end
  endtask

  // Model: after k edges since reset, slot = k mod R, digit = (k / R) mod N.
  task automatic step();
    int unsigned cnt, idx, nib;
    logic        blanked;
    logic [1:0]  ea;
    logic [6:0]  es;
    logic        esd;
    @(posedge clk);
    if (reset) begin
      k = 0; m_dig = '0; m_blk = '0;
    end else begin
      if (k % NR == 0) begin
        m_dig = ss_if.digits;
        m_blk = ss_if.blank;
      end
      k++;
    end
    #1;
    cnt     = k % R;
    idx     = (k / R) % N;
    nib     = 32'((m_dig >> (4 * idx)) & 8'hF);
    blanked = m_blk[idx] || (Lzb && idx >= 1 && (m_dig >> (4 * idx)) == 8'h0);
    ea      = 2'b11;
    es      = 7'h7F;
    if (cnt >= D) begin
      es = seg_ref[nib];
      if (!blanked) ea[idx] = 1'b0;
    end
    esd = (k > 0) && (k % NR == 0);
    check("model_anodes", 32'(ss_if.anodes), 32'(ea));
    check("model_segs", 32'(ss_if.segs), 32'(es));
    check("model_scan_done", 32'(ss_if.scan_done), 32'(esd));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic run_to(input int unsigned e);
    int guard = 0;
    while (k < e && guard < 1000) begin
      step();
      guard++;
    end
    if (k != e) begin
      errors++;
      $display("FAIL run_to: reached edge %0d required %0d", k, e);
    end
  endtask

  initial begin
    dec_tab[0]  = '{4'h0, 7'b1000000}; dec_tab[1]  = '{4'h1, 7'b1111001};
    dec_tab[2]  = '{4'h2, 7'b0100100}; dec_tab[3]  = '{4'h3, 7'b0110000};
    dec_tab[4]  = '{4'h4, 7'b0011001}; dec_tab[5]  = '{4'h5, 7'b0010010};
    dec_tab[6]  = '{4'h6, 7'b0000010}; dec_tab[7]  = '{4'h7, 7'b1111000};
    dec_tab[8]  = '{4'h8, 7'b0000000}; dec_tab[9]  = '{4'h9, 7'b0010000};
    dec_tab[10] = '{4'hA, 7'b0001000}; dec_tab[11] = '{4'hB, 7'b0000011};
    dec_tab[12] = '{4'hC, 7'b1000110}; dec_tab[13] = '{4'hD, 7'b0100001};
    dec_tab[14] = '{4'hE, 7'b0000110}; dec_tab[15] = '{4'hF, 7'b0001110};
    for (int i = 0; i < 16; i++) seg_ref[dec_tab[i].nib] = dec_tab[i].segs;
    k = 0; m_dig = '0; m_blk = '0;
    ss_if.digits = 8'h42;
    ss_if.blank  = 2'b00;

    // Basic scan
    do_reset();
    check("reset_anodes", 32'(ss_if.anodes), 32'h3);
    check("reset_segs", 32'(ss_if.segs), 32'h7F);
    run_to(2);
    check("basic_e2_anodes", 32'(ss_if.anodes), 32'b10);
    check("basic_e2_segs", 32'(ss_if.segs), 32'b0100100);
    run_to(7);
    check("basic_e7_anodes", 32'(ss_if.anodes), 32'b10);
    run_to(8);
    check("basic_e8_anodes", 32'(ss_if.anodes), 32'b11);
    run_to(10);
    check("basic_e10_anodes", 32'(ss_if.anodes), 32'b01);
    check("basic_e10_segs", 32'(ss_if.segs), 32'b0011001);
    run_to(15);
    check("basic_e15_done", 32'(ss_if.scan_done), 32'h0);
    run_to(16);
    check("basic_e16_done", 32'(ss_if.scan_done), 32'h1);
    check("basic_e16_anodes", 32'(ss_if.anodes), 32'b11);
    run_to(17);
    check("basic_e17_done", 32'(ss_if.scan_done), 32'h0);

    // Snapshot: mid-frame change shows only on the next frame
    ss_if.digits = 8'h42;
    do_reset();
    run_to(5);
    ss_if.digits = 8'hFF;
    for (int e = 10; e <= 15; e++) begin
      run_to(e);
      check("snap_digit1_segs", 32'(ss_if.segs), 32'b0011001);
    end
    run_to(18);
    check("snap_e18_segs", 32'(ss_if.segs), 32'b0001110);
    check("snap_e18_anodes", 32'(ss_if.anodes), 32'b10);

    // Blanking over two frames
    ss_if.digits = 8'h42;
    ss_if.blank  = 2'b10;
    do_reset();
    for (int e = 1; e <= 32; e++) begin
      run_to(e);
      check("blank_an1_high", 32'(ss_if.anodes[1]), 32'h1);
      check("blank_an0", 32'(ss_if.anodes[0]),
            32'(!((e >= 2 && e <= 7) || (e >= 18 && e <= 23))));
    end
    ss_if.blank = 2'b00;

    // Reset mid-slot while digit 1 is lit
    do_reset();
    run_to(11);
    check("rst_pre_anodes", 32'(ss_if.anodes), 32'b01);
    reset = 1'b1;
    step();
    check("rst_anodes", 32'(ss_if.anodes), 32'b11);
    check("rst_segs", 32'(ss_if.segs), 32'h7F);
    check("rst_done", 32'(ss_if.scan_done), 32'h0);
    reset = 1'b0;
    run_to(D - 1);
    check("rst_rel_dead", 32'(ss_if.anodes), 32'b11);
    run_to(D);
    check("rst_rel_lit", 32'(ss_if.anodes), 32'b10);
    check("rst_rel_segs", 32'(ss_if.segs), 32'b0100100);

    // Full decode sweep on digit 0
    for (int i = 0; i < 16; i++) begin
      ss_if.digits = {4'h1, dec_tab[i].nib};
      do_reset();
      run_to(D);
      check("decode_segs", 32'(ss_if.segs), 32'(dec_tab[i].segs));
      check("decode_anodes", 32'(ss_if.anodes), 32'b10);
    end

    // Leading-zero behaviour
    ss_if.digits = 8'h05;
    do_reset();
    run_to(R + D);
`ifdef SEVENSEG_LZB_EN
    check("lzb_an1_off", 32'(ss_if.anodes), 32'b11);
`else
    check("nolzb_an1_on", 32'(ss_if.anodes), 32'b01);
    check("nolzb_zero_segs", 32'(ss_if.segs), 32'b1000000);
`endif
    ss_if.digits = 8'h00;
    do_reset();
    run_to(D);
    check("zero_d0_anodes", 32'(ss_if.anodes), 32'b10);
    check("zero_d0_segs", 32'(ss_if.segs), 32'b1000000);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        ss_if.digits = ($urandom_range(0, 3) == 0) ? 8'(($urandom_range(0, 1)) << 4) :
                       8'($urandom);
        ss_if.blank  = 2'($urandom);
      end
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Parametrised, time-multiplexed seven-segment display driver for N hex digits sharing one active-low segment bus. It generalises the two-digit multiplexed display in the lab top level, adding a configurable digit count, per-digit blanking, anti-ghosting dead time and tear-free frame snapshots. It sits between the datapath (switch and sum nibbles) and the board's segment and anode pins.

## Interface
- N_DIGITS, 2: number of multiplexed digits; must be ≥1.
- REFRESH_CYCLES, 48000: clk cycles per digit slot (about 1 kHz at 48 MHz).
- DEAD_CYCLES, 16: cycles at the start of each slot with all anodes off; must be 1 ≤ DEAD_CYCLES < REFRESH_CYCLES.
- clk  in  1  system clock; all state on the rising edge.
- reset  in  1  synchronous, active-high reset.
- digits  in  4*N_DIGITS  hex nibbles; digit i = digits[4i+3:4i]; digit 0 is rightmost.
- blank  in  N_DIGITS  1 = digit i is not lit.
- segs  out  7  {g,f,e,d,c,b,a}, active-low, registered.
- anodes  out  N_DIGITS  digit enables, active-low, registered; at most one bit low.
- scan_done  out  1  one-cycle pulse at the end of each full scan.

## Operation
- State: slot counter cnt (0..REFRESH_CYCLES-1), digit index idx (0..N_DIGITS-1), phase DEAD/ON, snapshot registers snap_digits and snap_blank.
- Reset values: cnt=0, idx=0, phase=DEAD, anodes all 1, segs=7'b1111111, scan_done=0, snapshot cleared to 0.
- Each edge with reset low: cnt increments. At REFRESH_CYCLES-1 it wraps to 0 and idx advances, with idx wrapping N_DIGITS-1→0.
- Phase: DEAD while cnt < DEAD_CYCLES, otherwise ON.
- Snapshot: digits and blank are loaded on every edge where idx==0 and cnt==0, including the first edge after reset. The display shows only snapshot data, so input changes mid-scan appear at the next scan and never tear.
- DEAD: anodes all 1, segs all 1.
- ON: anodes[idx]=0 unless snap_blank[idx]=1, in which case all anodes stay 1. segs is the decode of snap nibble idx.
- Decode, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- scan_done: high for exactly one cycle following the edge where idx wraps N_DIGITS-1→0. With N_DIGITS=1 this occurs every REFRESH_CYCLES edges.
- Reset mid-operation: the next edge with reset high restores every reset value regardless of phase. The scan restarts at digit 0 with a fresh snapshot.

## Timing
- Outputs are registered and reflect the counter state after the same edge. No combinational input-to-output path.
- After reset release, take edge 1 as the first edge with reset low:
  - anodes[0] goes low after edge DEAD_CYCLES.
  - anodes[0] stays low through edge REFRESH_CYCLES-1.
  - All anodes go high after edge REFRESH_CYCLES.
  - Digit 1 lights after edge REFRESH_CYCLES+DEAD_CYCLES.
- Frame period is N_DIGITS*REFRESH_CYCLES cycles.
- Input-to-display latency is at most one frame plus one slot.
- Duty per digit is (REFRESH_CYCLES-DEAD_CYCLES)/(N_DIGITS*REFRESH_CYCLES).

## Configuration
- SEVENSEG_LZB_EN defined: leading-zero blanking.
  - Digit i≥1 is treated as blanked when snapshot nibbles i..N_DIGITS-1 are all zero.
  - This is ORed with snap_blank.
  - Digit 0 is never suppressed by this rule.
- SEVENSEG_LZB_EN undefined: only the blank input suppresses digits; zeros display as 1000000.

## Test plan
Use N_DIGITS=2, REFRESH_CYCLES=8, DEAD_CYCLES=2 for all scenarios.
- Basic scan: reset, digits=8'h42, blank=0.
  - After edge 2: anodes=2'b10, segs=0100100.
  - After edge 8: anodes=2'b11.
  - After edge 10: anodes=2'b01, segs=0011001.
  - After edge 16: scan_done=1 for one cycle, anodes=11.
- Snapshot: digits=8'h42, then set digits=8'hFF after edge 5.
  - Edges 10–15: digit 1 still shows 0011001.
  - After edge 18: digit 0 shows 0001110.
- Blanking: blank=2'b10 over two frames.
  - anodes[1] never 0.
  - anodes[0] low on edges 2–7 and 18–23.
- Reset mid-slot: assert reset on edge 12 (digit 1 lit).
  - After edge 12: anodes=11, segs=1111111, scan_done=0.
  - Release reset: digit 0 lights DEAD_CYCLES edges later.
- Full decode: sweep all 16 nibbles on digit 0; each segs value matches the table.
- Macro, digits=8'h05:
  - With SEVENSEG_LZB_EN: anodes[1] stays 1.
  - Without SEVENSEG_LZB_EN: digit 1 shows 1000000.
  - digits=8'h00 with the macro: digit 0 still shows 1000000.
